// File: rtl/fa_pkg.sv
// Shared constants and helpers for the ripple-carry full adder.
package fa_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MAX     = 64;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic fa_signed_ovf(input logic a_msb, input logic b_msb,
                                         input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell; chained by the top level to form the ripple adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/full_adder_please_work.sv
// Registered WIDTH-bit ripple-carry adder with one-cycle latency.
// Optional registered signed-overflow output ovf when FA_OVF_EN is defined.
module full_adder_please_work
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             C_out,
  output logic [WIDTH-1:0] S,
  output logic             out_valid
`ifdef FA_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > FA_WIDTH_MAX) begin : g_bad_width
    $error("full_adder_please_work: WIDTH %0d outside 1..%0d", WIDTH, FA_WIDTH_MAX);
  end

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic             r_c_out;
  logic [WIDTH-1:0] r_s;
  logic             r_valid;

  assign w_carry[0] = C_in;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    fa_cell u_cell (
      .a  (A[gi]),
      .b  (B[gi]),
      .ci (w_carry[gi]),
      .co (w_carry[gi+1]),
      .s  (w_sum[gi])
    );
  end

  // Result registers hold their value while no new operands arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s     <= w_sum;
        r_c_out <= w_carry[WIDTH];
      end
    end
  end

  assign S         = r_s;
  assign C_out     = r_c_out;
  assign out_valid = r_valid;

`ifdef FA_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= fa_signed_ovf(A[WIDTH-1], B[WIDTH-1], w_sum[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder_please_work.sv
// Directed self-checking bench: WIDTH=1, 8 and 4 instances of the registered adder.
module tb_full_adder_please_work;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // WIDTH=1 instance
  logic v1, a1, b1, c1, co1, s1, ov1;
  // WIDTH=8 instance
  logic v8, c8, co8, ov8;
  logic [7:0] a8, b8, s8;
  // WIDTH=4 instance
  logic v4, c4, co4, ov4;
  logic [3:0] a4, b4, s4;
`ifdef FA_OVF_EN
  logic of1, of8, of4;
`endif

  full_adder_please_work #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .C_in(c1),
    .C_out(co1), .S(s1), .out_valid(ov1)
`ifdef FA_OVF_EN
    , .ovf(of1)
`endif
  );

  full_adder_please_work #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .C_in(c8),
    .C_out(co8), .S(s8), .out_valid(ov8)
`ifdef FA_OVF_EN
    , .ovf(of8)
`endif
  );

  full_adder_please_work #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .C_in(c4),
    .C_out(co4), .S(s4), .out_valid(ov4)
`ifdef FA_OVF_EN
    , .ovf(of4)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp1 [8];
  logic [4:0] q4 [$];
  logic [4:0] e4;

  initial begin
    exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v4 = 0; a4 = 0; b4 = 0; c4 = 0;

    // Reset state before any clock edge
    #3;
    chk("rst_s8", s8, 0);
    chk("rst_co8", co8, 0);
    chk("rst_ov8", ov8, 0);
    chk("rst_ov1", ov1, 0);
`ifdef FA_OVF_EN
    chk("rst_ovf8", of8, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 exhaustive truth table, back-to-back
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("w1_sum_%0d", i-1), {co1, s1}, exp1[i-1]);
        chk($sformatf("w1_vld_%0d", i-1), ov1, 1);
      end
      if (i < 8) begin
        {a1, b1, c1} = 3'(i);
        v1 = 1'b1;
        $display("txn w1 A=%0d B=%0d C_in=%0d", a1, b1, c1);
      end else begin
        v1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("w1_vld_drop", ov1, 0);

    // WIDTH=8 wrap-around: FF + 00 + 1
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    $display("txn w8 A=ff B=00 C_in=1");
    @(negedge clk);
    v8 = 1'b0;
    chk("w8_wrap_s", s8, 8'h00);
    chk("w8_wrap_co", co8, 1);
    chk("w8_wrap_vld", ov8, 1);
`ifdef FA_OVF_EN
    chk("w8_wrap_ovf", of8, 0);
`endif

    // WIDTH=8 hold: 3C + 0F then idle for 3 cycles
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h0F; c8 = 1'b0; v8 = 1'b1;
    $display("txn w8 A=3c B=0f C_in=0");
    @(negedge clk);
    v8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w8_hold_s_%0d", k), s8, 8'h4B);
      chk($sformatf("w8_hold_co_%0d", k), co8, 0);
      chk($sformatf("w8_hold_vld_%0d", k), ov8, (k == 0) ? 1 : 0);
      @(negedge clk);
    end

`ifdef FA_OVF_EN
    // Signed overflow cases
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
    $display("txn w8 A=7f B=01 C_in=0");
    @(negedge clk);
    chk("ovf_pos_s", s8, 8'h80);
    chk("ovf_pos_ovf", of8, 1);
    chk("ovf_pos_co", co8, 0);
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    $display("txn w8 A=80 B=80 C_in=0");
    @(negedge clk);
    v8 = 1'b0;
    chk("ovf_neg_s", s8, 8'h00);
    chk("ovf_neg_ovf", of8, 1);
    chk("ovf_neg_co", co8, 1);
    @(negedge clk);
`endif

    // Asynchronous reset mid-cycle with a result just registered
    a8 = 8'h55; b8 = 8'hAA; c8 = 1'b1; v8 = 1'b1;
    $display("txn w8 A=55 B=aa C_in=1 then async rst");
    @(posedge clk);
    #2;
    chk("pre_rst_s", s8, 8'h00);
    chk("pre_rst_co", co8, 1);
    rst = 1'b1;
    #1;
    chk("arst_s", s8, 0);
    chk("arst_co", co8, 0);
    chk("arst_vld", ov8, 0);
`ifdef FA_OVF_EN
    chk("arst_ovf", of8, 0);
`endif
    @(negedge clk);
    v8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s", s8, 0);
    chk("post_rst_vld", ov8, 0);

    // First valid after reset is processed normally: 12 + 34 + 0 = 46
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; v8 = 1'b1;
    $display("txn w8 A=12 B=34 C_in=0");
    @(negedge clk);
    v8 = 1'b0;
    chk("first_s", s8, 8'h46);
    chk("first_vld", ov8, 1);

    // WIDTH=4 back-to-back random vectors against A+B+C_in
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        e4 = q4.pop_front();
        chk($sformatf("w4_sum_%0d", i-1), {co4, s4}, e4);
        chk($sformatf("w4_vld_%0d", i-1), ov4, 1);
      end
      if (i < 16) begin
        a4 = 4'($urandom_range(0, 15));
        b4 = 4'($urandom_range(0, 15));
        c4 = 1'($urandom_range(0, 1));
        v4 = 1'b1;
        q4.push_back({1'b0, a4} + {1'b0, b4} + {4'b0, c4});
        $display("txn w4 A=%0h B=%0h C_in=%0d", a4, b4, c4);
      end else begin
        v4 = 1'b0;
      end
      @(negedge clk);
    end
    chk("w4_vld_drop", ov4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
